tank_sprite_reader: RTL and testbench



---
 rtl/tank_sprite_pkg.sv | 48 ++++
 rtl/tank_sprite_reader_if.sv | 11 +
 rtl/sprite_line_buf.sv | 67 ++++++
 rtl/tank_sprite_reader.sv | 168 ++++++++++++++++
 tb/tb_tank_sprite_reader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tank_sprite_pkg.sv
// tank_sprite_pkg: sprite geometry, widths, enums and the rotation address map
// shared by the tank sprite read engine.
package tank_sprite_pkg;

    localparam int SPR_W   = 40;
    localparam int SPR_H   = 40;
    localparam int PIX_W   = 12;
    localparam int ADDR_W  = 12;
    localparam int COORD_W = 10;
    localparam int COL_W   = 6;

    localparam logic [PIX_W-1:0] TRANSP = 12'h000;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // One stored "up" image serves all headings by remapping row/col to a ROM address
    function automatic logic [ADDR_W-1:0] spr_addr(input logic [COL_W-1:0] row,
                                                   input logic [COL_W-1:0] col,
                                                   input dir_e dir);
        logic [ADDR_W-1:0] r;
        logic [ADDR_W-1:0] c;
        logic [ADDR_W-1:0] w;
        logic [ADDR_W-1:0] last;
        r    = ADDR_W'(row);
        c    = ADDR_W'(col);
        w    = ADDR_W'(SPR_W);
        last = ADDR_W'(SPR_W - 1);
        case (dir)
            DIR_UP:   spr_addr = r * w + c;
            DIR_DOWN: spr_addr = (last - r) * w + (last - c);
            DIR_LEFT: spr_addr = c * w + (last - r);
            default:  spr_addr = (last - c) * w + r;
        endcase
    endfunction

endpackage

// File: rtl/tank_sprite_reader_if.sv
// tank_sprite_reader_if: sprite ROM read bus (address out, data back).
interface tank_sprite_reader_if;
    import tank_sprite_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/sprite_line_buf.sv
// sprite_line_buf: two sprite-row banks; the back bank is filled while the
// front bank is displayed, and a swap exchanges them along with valid flags.
module sprite_line_buf
    import tank_sprite_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             swap,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_idx,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             set_valid,
    input  logic [COL_W-1:0] rd_idx,
    output logic [PIX_W-1:0] rd_data,
    output logic             front_valid
);

    logic bank_q, bank_d;
    logic front_valid_q, front_valid_d;
    logic back_valid_q, back_valid_d;
    logic [PIX_W-1:0] mem_q [2][SPR_W];

    // A swap hands the back bank's validity to the front and starts a fresh, invalid back bank
    always_comb begin
        bank_d        = bank_q;
        front_valid_d = front_valid_q;
        back_valid_d  = back_valid_q;
        if (swap) begin
            bank_d        = ~bank_q;
            front_valid_d = back_valid_q;
            back_valid_d  = 1'b0;
        end else if (set_valid) begin
            back_valid_d = 1'b1;
        end
    end

    // Bank select and valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q        <= 1'b0;
            front_valid_q <= 1'b0;
            back_valid_q  <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            front_valid_q <= front_valid_d;
            back_valid_q  <= back_valid_d;
        end
    end

    // Pixel storage needs no reset because the valid flags gate its use
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[bank_q][wr_idx] <= wr_data;
        end
    end

    // Front-bank read, returning zero for indices beyond the sprite width
    always_comb begin
        rd_data = '0;
        if (rd_idx < COL_W'(SPR_W)) begin
            rd_data = mem_q[~bank_q][rd_idx];
        end
    end

    assign front_valid = front_valid_q;

endmodule

// File: rtl/tank_sprite_reader.sv
// tank_sprite_reader: prefetches one sprite row per hblank into a double line
// buffer (with heading rotation) and emits the sprite pixel during active video.
// Build option: define SPR_TRANSP_EN to make colour TRANSP non-hitting.
module tank_sprite_reader
    import tank_sprite_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                line_start,
    input  logic [COORD_W-1:0]  next_line,
    input  logic [COORD_W-1:0]  hcount,
    input  logic [COORD_W-1:0]  spr_x,
    input  logic [COORD_W-1:0]  spr_y,
    input  logic [1:0]          spr_dir,
    input  logic                spr_en,
    tank_sprite_reader_if.master rom,
    output logic [PIX_W-1:0]    pix_out,
    output logic                pix_hit,
    output logic                busy
);

    localparam int DIFF_W = COORD_W + 1;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [COL_W-1:0]   row_q, row_d;
    dir_e               dir_q, dir_d;
    logic               en_q, en_d;
    logic [COORD_W-1:0] line_q, line_d;
    logic [COORD_W-1:0] spr_y_q, spr_y_d;
    logic [COORD_W-1:0] spr_x_back_q, spr_x_back_d;
    logic [COORD_W-1:0] spr_x_front_q, spr_x_front_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [PIX_W-1:0]   pix_out_q, pix_out_d;
    logic               pix_hit_q, pix_hit_d;

    logic [DIFF_W-1:0]  row_full;
    logic [DIFF_W-1:0]  col_off;
    logic               in_win;
    logic               swap;
    logic               wr_en;
    logic               set_valid;
    logic [COL_W-1:0]   wr_idx;
    logic [PIX_W-1:0]   rd_data;
    logic               front_valid;

    sprite_line_buf u_line_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .swap        (swap),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (rom.rom_data),
        .set_valid   (set_valid),
        .rd_idx      (col_off[COL_W-1:0]),
        .rd_data     (rd_data),
        .front_valid (front_valid)
    );

    // Prefetch sequencer; a line_start in any state swaps banks and restarts, aborting a partial fetch
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        dir_d         = dir_q;
        en_d          = en_q;
        line_d        = line_q;
        spr_y_d       = spr_y_q;
        spr_x_back_d  = spr_x_back_q;
        spr_x_front_d = spr_x_front_q;
        rom_addr_d    = rom_addr_q;
        swap          = 1'b0;
        wr_en         = 1'b0;
        set_valid     = 1'b0;
        wr_idx        = col_q - COL_W'(1);
        row_full      = {1'b0, line_q} - {1'b0, spr_y_q};
        if (line_start) begin
            swap          = 1'b1;
            line_d        = next_line;
            spr_y_d       = spr_y;
            spr_x_front_d = spr_x_back_q;
            spr_x_back_d  = spr_x;
            dir_d         = dir_e'(spr_dir);
            en_d          = spr_en;
            state_d       = CHECK;
        end else begin
            case (state_q)
                CHECK: begin
                    if (!en_q || (line_q < spr_y_q) || (row_full >= DIFF_W'(SPR_H))) begin
                        state_d = IDLE;
                    end else begin
                        row_d      = row_full[COL_W-1:0];
                        col_d      = '0;
                        rom_addr_d = spr_addr(row_full[COL_W-1:0], '0, dir_q);
                        state_d    = FETCH;
                    end
                end
                FETCH: begin
                    wr_en = (col_q != '0);
                    if (col_q == COL_W'(SPR_W - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        col_d      = col_q + COL_W'(1);
                        rom_addr_d = spr_addr(row_q, col_q + COL_W'(1), dir_q);
                    end
                end
                DRAIN: begin
                    wr_en     = 1'b1;
                    wr_idx    = COL_W'(SPR_W - 1);
                    set_valid = 1'b1;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Display lookup: the front row is shown starting at the spr_x captured with it
    always_comb begin
        col_off   = {1'b0, hcount} - {1'b0, spr_x_front_q};
        in_win    = front_valid && (hcount >= spr_x_front_q) && (col_off < DIFF_W'(SPR_W));
        pix_out_d = in_win ? rd_data : '0;
`ifdef SPR_TRANSP_EN
        pix_hit_d = in_win && (rd_data != TRANSP);
`else
        pix_hit_d = in_win;
`endif
    end

    // Sequencer, latched sprite parameters, ROM address and display output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            dir_q         <= DIR_UP;
            en_q          <= 1'b0;
            line_q        <= '0;
            spr_y_q       <= '0;
            spr_x_back_q  <= '0;
            spr_x_front_q <= '0;
            rom_addr_q    <= '0;
            pix_out_q     <= '0;
            pix_hit_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            dir_q         <= dir_d;
            en_q          <= en_d;
            line_q        <= line_d;
            spr_y_q       <= spr_y_d;
            spr_x_back_q  <= spr_x_back_d;
            spr_x_front_q <= spr_x_front_d;
            rom_addr_q    <= rom_addr_d;
            pix_out_q     <= pix_out_d;
            pix_hit_q     <= pix_hit_d;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign pix_out      = pix_out_q;
    assign pix_hit      = pix_hit_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tank_sprite_reader.sv
// tb_tank_sprite_reader: table vectors, hand-written abort/reset sequences and
// randomized line traffic, all checked every cycle against a line-level model.
module tb_tank_sprite_reader;

    typedef struct {
        int line;
        int y;
        int x;
        int dir;
        bit en;
        bit valid;
    } line_t;

    typedef struct {
        int line;
        int y;
        int x;
        int dir;
        bit en;
        int exp_addr0;
        int exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  next_line = '0;
    logic [9:0]  hcount = '0;
    logic [9:0]  spr_x = '0;
    logic [9:0]  spr_y = '0;
    logic [1:0]  spr_dir = '0;
    logic        spr_en = 1'b0;
    logic [11:0] pix_out;
    logic        pix_hit;
    logic        busy;

    logic [11:0] rom_mem [1600];

    int    checks = 0;
    int    failures = 0;
    line_t front;
    line_t back;
    int    age;
    bit    fok;
    int    last_addr;

    tank_sprite_reader_if rom_if ();

    tank_sprite_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .next_line  (next_line),
        .hcount     (hcount),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_dir    (spr_dir),
        .spr_en     (spr_en),
        .rom        (rom_if),
        .pix_out    (pix_out),
        .pix_hit    (pix_hit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Sprite ROM with one cycle of read latency
    always @(posedge clk) begin
        rom_if.rom_data <= (rom_if.rom_addr < 12'd1600) ? rom_mem[rom_if.rom_addr] : 12'h000;
    end

    // Row r of a rotated sprite, column c, comes from source pixel (sr, sc) of the up image
    function automatic int src_addr(input line_t p, input int c);
        int r, sr, sc;
        r = p.line - p.y;
        case (p.dir)
            0:       begin sr = r;      sc = c;      end
            1:       begin sr = 39 - r; sc = 39 - c; end
            2:       begin sr = c;      sc = 39 - r; end
            default: begin sr = 39 - c; sc = r;      end
        endcase
        return sr * 40 + sc;
    endfunction

    function automatic bit fetch_ok(input line_t p);
        return p.en && (p.line >= p.y) && (p.line - p.y < 40);
    endfunction

    function automatic int clip(input int h);
        if (h < 0) return 0;
        if (h > 639) return 639;
        return h;
    endfunction

    task automatic modelReset();
        front.valid = 1'b0;
        back.valid  = 1'b0;
        front.x     = 0;
        back.x      = 0;
        age         = 1000;
        fok         = 1'b0;
        last_addr   = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output
    task automatic applyStimulus(input int h, input bit ls, input line_t p);
        int ep;
        bit eh;
        bit eb;
        hcount     = 10'(h);
        line_start = ls;
        if (ls) begin
            next_line = 10'(p.line);
            spr_y     = 10'(p.y);
            spr_x     = 10'(p.x);
            spr_dir   = 2'(p.dir);
            spr_en    = p.en;
        end
        ep = 0;
        eh = 1'b0;
        if (front.valid && (h >= front.x) && (h - front.x < 40)) begin
            ep = int'(rom_mem[src_addr(front, h - front.x)]);
`ifdef SPR_TRANSP_EN
            eh = (ep != 0);
`else
            eh = 1'b1;
`endif
        end
        if (ls) begin
            front       = back;
            back        = p;
            back.valid  = 1'b0;
            age         = 0;
            fok         = fetch_ok(p);
        end else begin
            if (age < 1000) age++;
            if (age == 42 && fok) back.valid = 1'b1;
        end
        if (fok && age >= 1 && age <= 40) last_addr = src_addr(back, age - 1);
        eb = (age == 0) || (fok && age <= 41);
        @(posedge clk);
        #1;
        line_start = 1'b0;
        checkOutput("pix_out", 32'(pix_out), 32'(ep));
        checkOutput("pix_hit", 32'(pix_hit), 32'(eh));
        checkOutput("busy", 32'(busy), 32'(eb));
        checkOutput("rom_addr", 32'(rom_if.rom_addr), 32'(last_addr));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t  tbl [10];
        line_t p;
        line_t dummy;
        int    prev_x;
        int    busy_cnt;
        int    hit_cnt;
        int    gap;

        tbl[0] = '{105, 100, 200, 0, 1'b1, 200,  42};
        tbl[1] = '{103, 100, 300, 1, 1'b1, 1479, 42};
        tbl[2] = '{103, 100,  50, 2, 1'b1, 36,   42};
        tbl[3] = '{103, 100, 600, 3, 1'b1, 1563, 42};
        tbl[4] = '{ 99, 100, 100, 0, 1'b1, 3,    1};
        tbl[5] = '{140, 100, 100, 0, 1'b1, 3,    1};
        tbl[6] = '{110, 100, 100, 0, 1'b0, 3,    1};
        tbl[7] = '{139, 100,   0, 0, 1'b1, 1560, 42};
        tbl[8] = '{100, 100, 620, 1, 1'b1, 1599, 42};
        tbl[9] = '{120, 100, 700, 0, 1'b1, 800,  42};

        for (int i = 0; i < 1600; i++) rom_mem[i] = 12'($urandom_range(1, 4095));
        for (int i = 0; i < 30; i++) rom_mem[$urandom_range(0, 1599)] = 12'h000;
        rom_mem[205] = 12'h000;

        dummy = '{0, 0, 0, 0, 1'b0, 1'b0};
        modelReset();

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rom_addr", 32'(rom_if.rom_addr), 32'd0);
        checkOutput("reset_pix_out", 32'(pix_out), 32'd0);
        checkOutput("reset_pix_hit", 32'(pix_hit), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Table vectors: each line is displayed while the following vector fetches
        prev_x = 0;
        for (int i = 0; i < 10; i++) begin
            p = '{tbl[i].line, tbl[i].y, tbl[i].x, tbl[i].dir, tbl[i].en, 1'b0};
            busy_cnt = 0;
            for (int k = 0; k < 44; k++) begin
                applyStimulus(clip(prev_x - 2 + k), k == 0, p);
                if (busy) busy_cnt++;
                if (k == 1) checkOutput("vec_addr0", 32'(rom_if.rom_addr), 32'(tbl[i].exp_addr0));
            end
            checkOutput("vec_busy_len", 32'(busy_cnt), 32'(tbl[i].exp_busy));
            prev_x = tbl[i].x;
        end
        for (int k = 0; k < 44; k++) applyStimulus(clip(prev_x - 2 + k), k == 0, dummy);

        // Abort: restart 20 cycles into FETCH; the aborted line must never show
        p = '{110, 100, 100, 0, 1'b1, 1'b0};
        for (int k = 0; k < 22; k++) applyStimulus(0, k == 0, p);
        p = '{112, 100, 300, 2, 1'b1, 1'b0};
        hit_cnt = 0;
        for (int k = 0; k < 44; k++) begin
            applyStimulus(98 + k, k == 0, p);
            if (k == 1) checkOutput("abort_addr0", 32'(rom_if.rom_addr), 32'd27);
            if (k >= 1 && pix_hit) hit_cnt++;
        end
        checkOutput("abort_hits", 32'(hit_cnt), 32'd0);
        for (int k = 0; k < 44; k++) applyStimulus(298 + k, k == 0, dummy);

        // Reset in the middle of a fetch
        p = '{101, 100, 400, 0, 1'b1, 1'b0};
        for (int k = 0; k < 25; k++) applyStimulus(0, k == 0, p);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rom_addr", 32'(rom_if.rom_addr), 32'd0);
        checkOutput("midreset_pix_out", 32'(pix_out), 32'd0);
        checkOutput("midreset_pix_hit", 32'(pix_hit), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        hit_cnt = 0;
        for (int k = 0; k < 44; k++) begin
            applyStimulus(398 + k, k == 0, dummy);
            if (pix_hit) hit_cnt++;
        end
        checkOutput("midreset_hits", 32'(hit_cnt), 32'd0);

        // Randomized line traffic, including early line_starts that abort fetches
        for (int n = 0; n < 40; n++) begin
            p.y     = int'($urandom_range(2, 440));
            p.line  = p.y + int'($urandom_range(0, 44)) - 2;
            p.x     = int'($urandom_range(0, 700));
            p.dir   = int'($urandom_range(0, 3));
            p.en    = ($urandom_range(0, 7) != 0);
            p.valid = 1'b0;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 42)) : int'($urandom_range(43, 70));
            for (int k = 0; k < gap; k++) begin
                applyStimulus(clip(front.x - 3 + int'($urandom_range(0, 46))), k == 0, p);
            end
        end
        for (int k = 0; k < 44; k++) applyStimulus(clip(front.x - 2 + k), k == 0, dummy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
